// File: rtl/program_loader_if.sv
// Byte-stream and program-memory bus shared between the host link and program_loader.
interface program_loader_if;
  logic        Byte_Valid_i;
  logic [7:0]  Byte_Data_i;
  logic        Byte_Ready_o;
  logic        Mem_Write_o;
  logic [31:0] Mem_Address_o;
  logic [31:0] Mem_Data_o;

  modport slave (
    input  Byte_Valid_i, Byte_Data_i,
    output Byte_Ready_o, Mem_Write_o, Mem_Address_o, Mem_Data_o
  );

  modport master (
    output Byte_Valid_i, Byte_Data_i,
    input  Byte_Ready_o, Mem_Write_o, Mem_Address_o, Mem_Data_o
  );
endinterface

// File: rtl/program_loader.sv
// Boot loader: receives a length-prefixed byte stream and writes little-endian words to program memory.
// Define LOADER_CHECKSUM_EN to require a trailing modulo-256 checksum byte after the data.
module program_loader #(
  parameter int PROGRAM_MEMORY_DEPTH = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Start_i,
  program_loader_if.slave bus,
  output logic            Core_Reset_n_o,
  output logic            Done_o,
  output logic            Error_o,
  output logic [15:0]     Word_Count_o
);

  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR} state_t;

  localparam logic [16:0] LP_DEPTH = 17'(PROGRAM_MEMORY_DEPTH);

  state_t      r_state, w_state_nxt;
  logic        r_ready, w_ready_nxt;
  logic        r_write, w_write_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic [31:0] r_data, w_data_nxt;
  logic        r_core_rst_n, w_core_rst_n_nxt;
  logic        r_done, w_done_nxt;
  logic        r_error, w_error_nxt;
  logic [15:0] r_count, w_count_nxt;
  logic [15:0] r_len, w_len_nxt;
  logic [23:0] r_word, w_word_nxt;
  logic [1:0]  r_idx, w_idx_nxt;
  logic        w_take;
  logic [15:0] w_len_full;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  r_sum, w_sum_nxt;
`endif

  assign w_take     = r_ready & bus.Byte_Valid_i;
  assign w_len_full = {bus.Byte_Data_i, r_len[7:0]};

  always_comb begin
    w_state_nxt      = r_state;
    w_ready_nxt      = r_ready;
    w_write_nxt      = 1'b0;
    w_addr_nxt       = r_addr;
    w_data_nxt       = r_data;
    w_core_rst_n_nxt = r_core_rst_n;
    w_done_nxt       = r_done;
    w_error_nxt      = r_error;
    w_count_nxt      = r_count;
    w_len_nxt        = r_len;
    w_word_nxt       = r_word;
    w_idx_nxt        = r_idx;
`ifdef LOADER_CHECKSUM_EN
    w_sum_nxt        = r_sum;
`endif

    case (r_state)
      IDLE, DONE, ERROR: begin
        if (Start_i) begin
          w_state_nxt      = LEN_LO;
          w_ready_nxt      = 1'b1;
          w_count_nxt      = 16'd0;
          w_done_nxt       = 1'b0;
          w_error_nxt      = 1'b0;
          w_core_rst_n_nxt = 1'b0;
          w_idx_nxt        = 2'd0;
        end
      end

      LEN_LO: begin
        if (w_take) begin
          w_len_nxt   = {8'd0, bus.Byte_Data_i};
          w_state_nxt = LEN_HI;
`ifdef LOADER_CHECKSUM_EN
          w_sum_nxt   = bus.Byte_Data_i;
`endif
        end
      end

      LEN_HI: begin
        if (w_take) begin
          w_len_nxt = w_len_full;
          w_idx_nxt = 2'd0;
`ifdef LOADER_CHECKSUM_EN
          w_sum_nxt = r_sum + bus.Byte_Data_i;
`endif
          if (w_len_full == 16'd0) begin
            w_state_nxt      = DONE;
            w_ready_nxt      = 1'b0;
            w_done_nxt       = 1'b1;
            w_core_rst_n_nxt = 1'b1;
          end else if ({1'b0, w_len_full} > LP_DEPTH) begin
            w_state_nxt = ERROR;
            w_ready_nxt = 1'b0;
            w_error_nxt = 1'b1;
          end else begin
            w_state_nxt = DATA;
          end
        end
      end

      DATA: begin
        // The write cycle doubles as the bubble in which completion is decided.
        if (r_write) begin
          if (r_count == r_len) begin
`ifdef LOADER_CHECKSUM_EN
            w_state_nxt      = CHECK;
            w_ready_nxt      = 1'b1;
`else
            w_state_nxt      = DONE;
            w_done_nxt       = 1'b1;
            w_core_rst_n_nxt = 1'b1;
`endif
          end else begin
            w_ready_nxt = 1'b1;
          end
        end else if (w_take) begin
`ifdef LOADER_CHECKSUM_EN
          w_sum_nxt = r_sum + bus.Byte_Data_i;
`endif
          w_idx_nxt = r_idx + 2'd1;
          case (r_idx)
            2'd0: w_word_nxt[7:0]   = bus.Byte_Data_i;
            2'd1: w_word_nxt[15:8]  = bus.Byte_Data_i;
            2'd2: w_word_nxt[23:16] = bus.Byte_Data_i;
            default: begin
              w_ready_nxt = 1'b0;
              w_write_nxt = 1'b1;
              w_data_nxt  = {bus.Byte_Data_i, r_word};
              w_addr_nxt  = {14'd0, r_count, 2'b00};
              w_count_nxt = r_count + 16'd1;
            end
          endcase
        end
      end

`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (w_take) begin
          w_ready_nxt = 1'b0;
          if (bus.Byte_Data_i == r_sum) begin
            w_state_nxt      = DONE;
            w_done_nxt       = 1'b1;
            w_core_rst_n_nxt = 1'b1;
          end else begin
            w_state_nxt = ERROR;
            w_error_nxt = 1'b1;
          end
        end
      end
`endif

      default: begin
        w_state_nxt = IDLE;
        w_ready_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_ready      <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= 32'd0;
      r_data       <= 32'd0;
      r_core_rst_n <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_count      <= 16'd0;
      r_len        <= 16'd0;
      r_word       <= 24'd0;
      r_idx        <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
      r_sum        <= 8'd0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_ready      <= w_ready_nxt;
      r_write      <= w_write_nxt;
      r_addr       <= w_addr_nxt;
      r_data       <= w_data_nxt;
      r_core_rst_n <= w_core_rst_n_nxt;
      r_done       <= w_done_nxt;
      r_error      <= w_error_nxt;
      r_count      <= w_count_nxt;
      r_len        <= w_len_nxt;
      r_word       <= w_word_nxt;
      r_idx        <= w_idx_nxt;
`ifdef LOADER_CHECKSUM_EN
      r_sum        <= w_sum_nxt;
`endif
    end
  end

  assign bus.Byte_Ready_o  = r_ready;
  assign bus.Mem_Write_o   = r_write;
  assign bus.Mem_Address_o = r_addr;
  assign bus.Mem_Data_o    = r_data;
  assign Core_Reset_n_o    = r_core_rst_n;
  assign Done_o            = r_done;
  assign Error_o           = r_error;
  assign Word_Count_o      = r_count;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: directed and random sessions checked against a session-level model.
// Honours LOADER_CHECKSUM_EN the same way as the design.
module tb_program_loader;

  localparam int DEPTH = 64;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start_i;
  logic        Core_Reset_n_o;
  logic        Done_o;
  logic        Error_o;
  logic [15:0] Word_Count_o;

  program_loader_if bus ();

  program_loader #(.PROGRAM_MEMORY_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .Start_i        (Start_i),
    .bus            (bus.slave),
    .Core_Reset_n_o (Core_Reset_n_o),
    .Done_o         (Done_o),
    .Error_o        (Error_o),
    .Word_Count_o   (Word_Count_o)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  wr_t         expQ[$];
  logic [31:0] progWords[$];
  logic [31:0] lastAddr = 32'd0;
  logic [31:0] lastData = 32'd0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name, input string what);
    checks++;
    errors++;
    $display("[TB] FAIL %s: %s", name, what);
  endtask

  // Every write the DUT issues must match the oldest expected write; between writes the bus holds.
  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        lastAddr = 32'd0;
        lastData = 32'd0;
      end else if (bus.Mem_Write_o) begin
        if (expQ.size() == 0) begin
          failNow("unexpected_write", $sformatf("got write addr 0x%0h data 0x%0h, expected none",
                                                bus.Mem_Address_o, bus.Mem_Data_o));
        end else begin
          e = expQ.pop_front();
          checkOutput("write_addr", bus.Mem_Address_o, e.addr);
          checkOutput("write_data", bus.Mem_Data_o, e.data);
          checkOutput("ready_in_write", 32'(bus.Byte_Ready_o), 32'd0);
          checkOutput("count_in_write", 32'(Word_Count_o), (e.addr >> 2) + 32'd1);
          lastAddr = e.addr;
          lastData = e.data;
        end
      end else begin
        checkOutput("addr_hold", bus.Mem_Address_o, lastAddr);
        checkOutput("data_hold", bus.Mem_Data_o, lastData);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // gapMode 0: back-to-back valid; 1: valid toggles 1/0; 2: random idle cycles.
  task automatic applyStimulus(input logic [7:0] b, input int gapMode);
    int idle;
    int guard;
    idle = (gapMode == 1) ? 1 : (gapMode == 2) ? int'($urandom_range(0, 2)) : 0;
    repeat (idle) begin
      bus.Byte_Valid_i = 1'b0;
      bus.Byte_Data_i  = 8'($urandom);
      @(posedge clk); #1;
    end
    bus.Byte_Valid_i = 1'b1;
    bus.Byte_Data_i  = b;
    guard = 0;
    @(negedge clk);
    while (!bus.Byte_Ready_o && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.Byte_Ready_o) failNow("byte_accept", "got Byte_Ready_o stuck low, expected acceptance");
    @(posedge clk); #1;
    bus.Byte_Valid_i = 1'b0;
  endtask

  task automatic pulseStart();
    @(posedge clk); #1;
    Start_i = 1'b1;
    @(posedge clk); #1;
    Start_i = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ready"}, 32'(bus.Byte_Ready_o), 32'd0);
    checkOutput({tag, "_write"}, 32'(bus.Mem_Write_o), 32'd0);
    checkOutput({tag, "_addr"}, bus.Mem_Address_o, 32'd0);
    checkOutput({tag, "_data"}, bus.Mem_Data_o, 32'd0);
    checkOutput({tag, "_core_rst_n"}, 32'(Core_Reset_n_o), 32'd0);
    checkOutput({tag, "_done"}, 32'(Done_o), 32'd0);
    checkOutput({tag, "_error"}, 32'(Error_o), 32'd0);
    checkOutput({tag, "_count"}, 32'(Word_Count_o), 32'd0);
  endtask

  // Session-level model: length N, then N words, optional checksum byte; csumDelta corrupts it.
  task automatic runSession(input int n, input int gapMode, input int csumDelta, input string name);
    logic [15:0] nv;
    logic [7:0]  sum;
    logic [7:0]  b;
    logic [31:0] w;
    wr_t         e;
    bit          expDone;
    bit          expErr;
    int          expCount;
    int          guard;
    nv  = 16'(n);
    sum = 8'd0;
    pulseStart();
    applyStimulus(nv[7:0], gapMode);
    sum = sum + nv[7:0];
    applyStimulus(nv[15:8], gapMode);
    sum = sum + nv[15:8];
    if (n == 0) begin
      expDone = 1'b1; expErr = 1'b0; expCount = 0;
    end else if (n > DEPTH) begin
      expDone = 1'b0; expErr = 1'b1; expCount = 0;
    end else begin
      for (int i = 0; i < n; i++) begin
        w = progWords[i];
        e.addr = 32'(4 * i);
        e.data = w;
        expQ.push_back(e);
        for (int k = 0; k < 4; k++) begin
          b = 8'(w >> (8 * k));
          applyStimulus(b, gapMode);
          sum = sum + b;
        end
      end
      expCount = n;
`ifdef LOADER_CHECKSUM_EN
      applyStimulus(sum + 8'(csumDelta), gapMode);
      expDone = (csumDelta == 0);
      expErr  = (csumDelta != 0);
`else
      expDone = 1'b1; expErr = 1'b0;
`endif
    end
    guard = 0;
    @(negedge clk);
    while (!(Done_o || Error_o) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!(Done_o || Error_o)) failNow({name, "_end"}, "got no Done_o/Error_o, expected session end");
    checkOutput({name, "_done"}, 32'(Done_o), 32'(expDone));
    checkOutput({name, "_error"}, 32'(Error_o), 32'(expErr));
    checkOutput({name, "_core_rst_n"}, 32'(Core_Reset_n_o), 32'(expDone));
    checkOutput({name, "_count"}, 32'(Word_Count_o), 32'(expCount));
    checkOutput({name, "_ready"}, 32'(bus.Byte_Ready_o), 32'd0);
    checkOutput({name, "_pending"}, 32'(expQ.size()), 32'd0);
    expQ.delete();
  endtask

  initial begin : stimulus
    int n;
    reset            = 1'b0;
    Start_i          = 1'b0;
    bus.Byte_Valid_i = 1'b0;
    bus.Byte_Data_i  = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("por");
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    progWords.delete();
    progWords.push_back(32'h00500513);
    progWords.push_back(32'h00A00593);
    runSession(2, 0, 0, "n2_stream");
    runSession(2, 1, 0, "n2_toggle");
    runSession(0, 0, 0, "n0");
    runSession(65, 0, 0, "n65");

`ifdef LOADER_CHECKSUM_EN
    progWords.delete();
    progWords.push_back(32'h00000013);
    runSession(1, 0, 0, "csum_good");
    runSession(1, 0, 1, "csum_bad");
`endif

    // Reset two bytes into a word: outputs clear at once and the partial word is discarded.
    progWords.delete();
    progWords.push_back(32'h00500513);
    runSession(1, 0, 0, "pre_reset");
    pulseStart();
    applyStimulus(8'd2, 0);
    applyStimulus(8'd0, 0);
    applyStimulus(8'hAA, 0);
    applyStimulus(8'hBB, 0);
    reset = 1'b0;
    #1;
    checkResetOutputs("mid_reset");
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("post_reset_count", 32'(Word_Count_o), 32'd0);
    checkOutput("post_reset_ready", 32'(bus.Byte_Ready_o), 32'd0);

    for (int s = 0; s < 6; s++) begin
      n = int'($urandom_range(1, 8));
      progWords.delete();
      for (int i = 0; i < n; i++) progWords.push_back($urandom);
      runSession(n, int'($urandom_range(0, 2)), 0, $sformatf("rand%0d", s));
    end

    progWords.delete();
    for (int i = 0; i < DEPTH; i++) progWords.push_back($urandom);
    runSession(DEPTH, 0, 0, "full_depth");

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
